// File: rtl/memory_output.sv
// memory_output: DEPTH-word result store with post-reset clear sweep and valid/ready in-order drain.
// Define MEMORY_OUTPUT_ACCUM_EN to make accepted writes accumulate (mem += data, wrapping) instead of overwrite.
module memory_output #(
    parameter int DATA_WIDTH = 20,
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_write_req_a,
    input  logic [ADDR_WIDTH-1:0] s_write_addr_a,
    input  logic [DATA_WIDTH-1:0] s_write_data_a,
    output logic                  s_write_ready_a,
    input  logic                  drain_start,
    output logic                  drain_busy,
    output logic                  drain_done,
    output logic                  m_data_valid,
    input  logic                  m_data_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [ADDR_WIDTH-1:0] m_addr
);
    typedef enum logic [1:0] {CLEAR, IDLE, DRAIN, DONE} state_t;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
    state_t                state;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH-1:0] mem_wa;
    logic [DATA_WIDTH-1:0] mem_wd;
    logic [DATA_WIDTH-1:0] wr_word;
    logic                  mem_we;
    logic                  last;
    assign last = m_addr == LAST;
    // valid low inside DRAIN marks the entry cycle, which always starts from address 0
    assign rd_addr = m_data_valid ? m_addr + 1'b1 : '0;
`ifdef MEMORY_OUTPUT_ACCUM_EN
    assign wr_word = mem[s_write_addr_a] + s_write_data_a;
`else
    assign wr_word = s_write_data_a;
`endif
    always_comb begin
        mem_we = !reset && (state == CLEAR || (state == IDLE && s_write_req_a && s_write_ready_a));
        mem_wa = state == CLEAR ? ptr : s_write_addr_a;
        mem_wd = state == CLEAR ? '0 : wr_word;
    end
    always_ff @(posedge clk)
        if (mem_we) mem[mem_wa] <= mem_wd;
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= CLEAR;
            ptr             <= '0;
            s_write_ready_a <= 1'b0;
            drain_busy      <= 1'b0;
            drain_done      <= 1'b0;
            m_data_valid    <= 1'b0;
            m_data          <= '0;
            m_addr          <= '0;
        end else begin
            drain_done <= 1'b0;
            case (state)
                CLEAR: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == LAST) begin
                        state           <= IDLE;
                        s_write_ready_a <= 1'b1;
                    end
                end
                IDLE: if (drain_start) begin
                    state           <= DRAIN;
                    s_write_ready_a <= 1'b0;
                    drain_busy      <= 1'b1;
                end
                DRAIN: if (!m_data_valid || (m_data_ready && !last)) begin
                    m_data       <= mem[rd_addr];
                    m_addr       <= rd_addr;
                    m_data_valid <= 1'b1;
                end else if (m_data_ready) begin
                    m_data_valid <= 1'b0;
                    drain_busy   <= 1'b0;
                    drain_done   <= 1'b1;
                    state        <= DONE;
                end
                DONE: begin
                    state           <= IDLE;
                    s_write_ready_a <= 1'b1;
                end
                default: state <= CLEAR;
            endcase
        end
    end
endmodule

// File: tb/tb_memory_output.sv
// tb_memory_output: table vectors, hand sequences and random writes checked against an array model of the store.
module tb_memory_output;
    localparam int DW = 20;
    localparam int AW = 10;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          s_write_req_a = 1'b0;
    logic [AW-1:0] s_write_addr_a = '0;
    logic [DW-1:0] s_write_data_a = '0;
    logic          s_write_ready_a;
    logic          drain_start = 1'b0;
    logic          drain_busy;
    logic          drain_done;
    logic          m_data_valid;
    logic          m_data_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic [AW-1:0] m_addr;

    memory_output #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .s_write_req_a(s_write_req_a), .s_write_addr_a(s_write_addr_a),
        .s_write_data_a(s_write_data_a), .s_write_ready_a(s_write_ready_a),
        .drain_start(drain_start), .drain_busy(drain_busy), .drain_done(drain_done),
        .m_data_valid(m_data_valid), .m_data_ready(m_data_ready),
        .m_data(m_data), .m_addr(m_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [DW-1:0] exp;
    } vec_t;

    int            checks = 0;
    int            failures = 0;
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] got [DEPTH];
    vec_t          tbl [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
`ifdef MEMORY_OUTPUT_ACCUM_EN
        ref_mem[a] = ref_mem[a] + d;
`else
        ref_mem[a] = d;
`endif
    endtask

    task automatic model_zero;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        s_write_req_a = 1'b1;
        s_write_addr_a = a;
        s_write_data_a = d;
        check("write_ready", s_write_ready_a, 1);
        if (s_write_ready_a) model_write(a, d);
        tick;
        s_write_req_a = 1'b0;
    endtask

    task automatic wait_clear;
        int n = 0;
        while (!s_write_ready_a && n < 2 * DEPTH) begin
            tick;
            n++;
        end
        check("clear_cycles", n, DEPTH);
        model_zero();
    endtask

    task automatic start_drain(input bit with_wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit poke);
        drain_start = 1'b1;
        if (with_wr) begin
            s_write_req_a = 1'b1;
            s_write_addr_a = a;
            s_write_data_a = d;
            check("same_cycle_write_ready", s_write_ready_a, 1);
            model_write(a, d);
        end
        tick;
        drain_start = 1'b0;
        s_write_req_a = 1'b0;
        check("busy_on_drain", drain_busy, 1);
        check("ready_low_in_drain", s_write_ready_a, 0);
        if (poke) begin
            s_write_req_a = 1'b1;
            s_write_addr_a = 10;
            s_write_data_a = 20'h55555;
            check("write_ready_in_drain", s_write_ready_a, 0);
        end
    endtask

    // mode 0: ready always high, 1: toggles starting low, 2: random
    task automatic run_drain(input int mode, input int abort_at, output bit aborted);
        int idx = 0, vcnt = 0, dcnt = 0, bad = 0, badaddr = 0;
        bit stalled = 0, tog = 0, rdy;
        logic [DW-1:0] hd;
        logic [AW-1:0] ha;
        aborted = 0;
        for (int b = 0; b < 4 * DEPTH + 8 && idx < DEPTH; b++) begin
            tick;
            s_write_req_a = 1'b0;
            if (drain_done) dcnt++;
            if (stalled && (m_data_valid !== 1'b1 || m_data !== hd || m_addr !== ha)) bad++;
            stalled = 0;
            if (m_data_valid) begin
                if (abort_at == idx) begin
                    reset = 1'b1;
                    m_data_ready = 1'b0;
                    aborted = 1;
                    return;
                end
                vcnt++;
                rdy = mode == 0 ? 1'b1 : mode == 1 ? tog : 1'($urandom_range(0, 1));
                tog = !tog;
                m_data_ready = rdy;
                if (rdy) begin
                    if (m_addr !== AW'(idx)) badaddr++;
                    if (m_data !== ref_mem[idx]) begin
                        if (bad == 0) $display("FAIL drain_word addr=%0d actual=%0h required=%0h", idx, m_data, ref_mem[idx]);
                        bad++;
                    end
                    got[idx] = m_data;
                    idx++;
                end else begin
                    stalled = 1;
                    hd = m_data;
                    ha = m_addr;
                end
            end
        end
        check("drain_words_taken", idx, DEPTH);
        tick;
        if (drain_done) dcnt++;
        check("done_after_last", drain_done, 1);
        check("valid_low_after_last", m_data_valid, 0);
        check("busy_low_after_last", drain_busy, 0);
        m_data_ready = 1'b0;
        tick;
        check("done_one_cycle", drain_done, 0);
        check("idle_ready_after_done", s_write_ready_a, 1);
        check("done_pulse_count", dcnt, 1);
        check("drain_data_errors", bad, 0);
        check("drain_addr_errors", badaddr, 0);
        if (mode == 0) check("valid_cycles_full", vcnt, DEPTH);
        if (mode == 1) check("valid_cycles_toggle", vcnt, 2 * DEPTH);
    endtask

    initial begin
        bit ab;
        logic [DW-1:0] exp3, exp7;
        tbl[0] = '{10'd5, 20'h12345, 20'h12345};
        tbl[1] = '{10'd1023, 20'hABCDE, 20'hABCDE};
        tbl[2] = '{10'd100, 20'h00001, 20'h00001};
        tbl[3] = '{10'd512, 20'hFFFFF, 20'hFFFFF};
`ifdef MEMORY_OUTPUT_ACCUM_EN
        exp3 = 20'd14;
        exp7 = 20'd1;
`else
        exp3 = 20'd9;
        exp7 = 20'd2;
`endif
        tick;
        tick;
        check("rst_write_ready", s_write_ready_a, 0);
        check("rst_busy", drain_busy, 0);
        check("rst_done", drain_done, 0);
        check("rst_valid", m_data_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_addr", m_addr, 0);
        reset = 1'b0;
        wait_clear();

        start_drain(0, 0, 0, 0);
        run_drain(0, -1, ab);

        for (int i = 0; i < 4; i++) do_write(tbl[i].addr, tbl[i].data);
        start_drain(0, 0, 0, 0);
        run_drain(0, -1, ab);
        for (int i = 0; i < 4; i++) check("table_word", got[tbl[i].addr], tbl[i].exp);

        start_drain(0, 0, 0, 0);
        run_drain(1, -1, ab);

        start_drain(1, 10'd0, 20'd7, 1);
        run_drain(2, -1, ab);
        check("same_cycle_first_word", got[0], 7);
        check("write_in_drain_ignored", got[10], 0);

        do_write(10'd3, 20'd5);
        do_write(10'd3, 20'd9);
        do_write(10'd7, 20'hFFFFF);
        do_write(10'd7, 20'd2);
        start_drain(0, 0, 0, 0);
        run_drain(0, -1, ab);
        check("back_to_back_addr3", got[3], exp3);
        check("back_to_back_wrap_addr7", got[7], exp7);

        for (int i = 0; i < 60; i++) do_write(AW'($urandom_range(0, DEPTH - 1)), DW'($urandom));
        start_drain(0, 0, 0, 0);
        run_drain(2, -1, ab);

        start_drain(0, 0, 0, 0);
        run_drain(0, 300, ab);
        check("abort_reached_word_300", ab, 1);
        tick;
        check("abort_valid", m_data_valid, 0);
        check("abort_busy", drain_busy, 0);
        check("abort_m_addr", m_addr, 0);
        check("abort_m_data", m_data, 0);
        check("abort_write_ready", s_write_ready_a, 0);
        reset = 1'b0;
        wait_clear();
        start_drain(0, 0, 0, 0);
        run_drain(0, -1, ab);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/memory_output.md
# memory_output

Output-side counterpart to the convolution input memory. It takes single-word writes from the convolution datapath into a DEPTH-word array. On command, it drains the whole array in address order over a valid/ready stream for result collection. After reset it zero-fills itself with a hardware clear sweep, so result locations start at a known value. An optional accumulate mode turns each write into a read-modify-write add, for partial-sum collection.

## Interface
Parameters:
- DATA_WIDTH, 20, width of one stored word
- ADDR_WIDTH, 10, address width
- DEPTH, 1<<ADDR_WIDTH, number of words (must equal 1<<ADDR_WIDTH)

Ports:
- clk  input  1  clock; all logic on rising edge
- reset  input  1  synchronous, active-high
- s_write_req_a  input  1  write request
- s_write_addr_a  input  ADDR_WIDTH  write address
- s_write_data_a  input  DATA_WIDTH  write data
- s_write_ready_a  output  1  write accepted when req&ready; high only in IDLE
- drain_start  input  1  single-cycle drain command; honoured only in IDLE
- drain_busy  output  1  high in DRAIN
- drain_done  output  1  one-cycle pulse after the last word is taken
- m_data_valid  output  1  stream word valid
- m_data_ready  input  1  stream consumer ready
- m_data  output  DATA_WIDTH  stream word
- m_addr  output  ADDR_WIDTH  address of m_data

## Operation
- FSM states: CLEAR, IDLE, DRAIN, DONE.
- Reset state is CLEAR. Reset values: s_write_ready_a=0, drain_busy=0, drain_done=0, m_data_valid=0, m_data=0, m_addr=0, clear/read pointer=0.
- **CLEAR:** writes mem[ptr]=0 and increments ptr each cycle. After ptr=DEPTH-1 is written, go to IDLE with ptr=0. Takes exactly DEPTH cycles.
- **IDLE:** s_write_ready_a=1. An accepted write stores to mem[addr] at that edge. drain_start=1 moves to DRAIN.
- **DRAIN:**
  - Entry cycle: loads m_data=mem[0], m_addr=0, sets m_data_valid.
  - On each handshake (valid&ready) with m_addr<DEPTH-1, load the next word at the same edge. Valid stays high, giving full throughput.
  - Without a handshake, m_data and m_addr hold.
  - A handshake at m_addr=DEPTH-1 clears valid and moves to DONE.
- **DONE:** drain_done=1 for one cycle, then IDLE. Memory contents are retained; a drain does not clear.
- Writes outside IDLE are not accepted (ready=0) and have no effect. drain_start outside IDLE is ignored.
- Write and drain_start in the same IDLE cycle: the write is accepted, and the drain includes it.
- Back-to-back writes to the same address: the last one wins (non-accumulate).
- Reset mid-drain or mid-clear: outputs return to reset values next cycle, and the full CLEAR sweep restarts.

## Timing
- Write latency: data in the array at the accepting edge. It is visible to a drain issued in the same or any later cycle.
- Drain start: drain_start sampled at edge t → DRAIN at t+1 → m_data_valid=1, m_addr=0 after edge t+1.
- With m_data_ready held high: one word per cycle, DEPTH valid cycles. drain_done is high in the cycle after the last handshake. IDLE (ready=1) one cycle later.
- Post-reset: s_write_ready_a rises exactly DEPTH cycles after reset deasserts.

## Configuration
- Macro: MEMORY_OUTPUT_ACCUM_EN.
- **Defined:** an accepted write performs mem[addr] = mem[addr] + s_write_data_a in one cycle. The sum wraps modulo 2^DATA_WIDTH (unsigned, carry discarded). Back-to-back writes to the same address both accumulate.
- **Undefined:** an accepted write overwrites mem[addr]. No adder is present.
- The CLEAR sweep, FSM and timing are identical in both builds.

## Test plan
- Reset, then a full drain with ready=1: ready rises at cycle DEPTH; the stream yields DEPTH words all 0, m_addr 0..DEPTH-1; drain_done pulses once.
- Write addr 5=0x12345, addr 1023=0xABCDE, then drain: word 5=0x12345, word 1023=0xABCDE, all others 0.
- Drain with m_data_ready toggling 1/0 every cycle: no word lost or duplicated, data holds while stalled, 2·DEPTH cycles of valid.
- Write and drain_start in the same cycle (addr 0=7): first streamed word is 7. A write attempted during DRAIN sees ready=0 and leaves the array unchanged.
- Reset asserted at drain word 300: valid=0 the next cycle, the CLEAR sweep reruns, and a subsequent drain returns all zeros.
- MEMORY_OUTPUT_ACCUM_EN defined: write addr 3 with 5 then 9 back-to-back gives 14. Write 0xFFFFF then 2 gives 1 (wrap).
